// File: rtl/retire_trace_buffer_pkg.sv
// Shared definitions for the retire trace buffer: capture FSM states and
// the width of one stored {trig, inst, dbg} entry.
package retire_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_POST  = 2'b10,
    ST_DONE  = 2'b11
  } trace_state_e;

  function automatic int entry_width(input int inst_w, input int dbg_w);
    return 1 + inst_w + dbg_w;
  endfunction

endpackage

// File: rtl/retire_trace_buffer_ram.sv
// Simple dual-port trace storage: one write port, one synchronous read port
// with a registered read-data output.
module retire_trace_buffer_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 49,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM macros; validity is
  // tracked by the controller's count, never by the contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Trace capture beside the single-cycle core: circular history of retired
// instructions, masked-match trigger, post-trigger window, then drain in DONE.
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int INST_W    = 32,
  parameter int DBG_W     = 16,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [INST_W-1:0] trig_inst,
  input  logic [INST_W-1:0] trig_mask,
  input  logic              cap_valid,
  input  logic [INST_W-1:0] cap_inst,
  input  logic [DBG_W-1:0]  cap_dbg,
  output logic [1:0]        state_o,
  output logic              done,
  output logic [CW-1:0]     count_o,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [INST_W-1:0] rd_inst,
  output logic [DBG_W-1:0]  rd_dbg,
  output logic              rd_trig,
  output logic              rd_last
);

  localparam int EW = entry_width(INST_W, DBG_W);

  trace_state_e  state, state_nxt;
  logic [AW-1:0] wr_ptr, post_cnt, rd_addr;
  logic [CW-1:0] count;
  logic          match, wr_en, trig_wr, pop;
  logic [EW-1:0] wr_data, rd_data;

  assign match   = cap_valid && (((cap_inst ^ trig_inst) & trig_mask) == '0);
  // Oldest entry; with a full buffer count's low bits are zero, so it is wr_ptr.
  assign rd_addr = wr_ptr - count[AW-1:0];
  assign wr_data = {trig_wr, cap_inst, cap_dbg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    if (arm) begin
      state_nxt = ST_ARMED;
    end else begin
      unique case (state)
        ST_IDLE:  state_nxt = ST_IDLE;
        ST_ARMED: if (match) state_nxt = (POST_TRIG == 0) ? ST_DONE : ST_POST;
        ST_POST:  if (cap_valid && post_cnt == AW'(1)) state_nxt = ST_DONE;
        ST_DONE:  if (pop && count == CW'(1)) state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    trig_wr = 1'b0;
    pop     = 1'b0;
    if (!arm) begin
      wr_en   = cap_valid && (state == ST_ARMED || state == ST_POST);
      trig_wr = match && state == ST_ARMED;
      pop     = rd_req && state == ST_DONE && count != '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= pop;
      rd_last  <= pop && count == CW'(1);
      if (arm) begin
        wr_ptr   <= '0;
        count    <= '0;
        post_cnt <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (count != CW'(DEPTH)) count <= count + CW'(1);
        if (trig_wr)                post_cnt <= AW'(POST_TRIG);
        else if (state == ST_POST)  post_cnt <= post_cnt - AW'(1);
      end else if (pop) begin
        count <= count - CW'(1);
      end
    end
  end

  retire_trace_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign {rd_trig, rd_inst, rd_dbg} = rd_data;
  assign state_o = state;
  assign done    = (state == ST_DONE);
  assign count_o = count;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer: DEPTH=8 with POST_TRIG=3 (dut) and
// POST_TRIG=0 (dut0) sharing one set of inputs.
module tb_retire_trace_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm = 1'b0;
  logic [31:0] trig_inst = '0;
  logic [31:0] trig_mask = '0;
  logic        cap_valid = 1'b0;
  logic [31:0] cap_inst  = '0;
  logic [15:0] cap_dbg   = '0;
  logic        rd_req    = 1'b0;

  logic [1:0]  state_o, z_state;
  logic        done, z_done;
  logic [3:0]  count_o, z_count;
  logic        rd_valid, z_rd_valid;
  logic [31:0] rd_inst, z_rd_inst;
  logic [15:0] rd_dbg, z_rd_dbg;
  logic        rd_trig, z_rd_trig;
  logic        rd_last, z_rd_last;

  int checks = 0;
  int errors = 0;

  retire_trace_buffer #(.INST_W(32), .DBG_W(16), .DEPTH(8), .POST_TRIG(3)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig_inst(trig_inst), .trig_mask(trig_mask),
    .cap_valid(cap_valid), .cap_inst(cap_inst), .cap_dbg(cap_dbg),
    .state_o(state_o), .done(done), .count_o(count_o), .rd_req(rd_req),
    .rd_valid(rd_valid), .rd_inst(rd_inst), .rd_dbg(rd_dbg),
    .rd_trig(rd_trig), .rd_last(rd_last)
  );

  retire_trace_buffer #(.INST_W(32), .DBG_W(16), .DEPTH(8), .POST_TRIG(0)) dut0 (
    .clk(clk), .rst(rst), .arm(arm), .trig_inst(trig_inst), .trig_mask(trig_mask),
    .cap_valid(cap_valid), .cap_inst(cap_inst), .cap_dbg(cap_dbg),
    .state_o(z_state), .done(z_done), .count_o(z_count), .rd_req(rd_req),
    .rd_valid(z_rd_valid), .rd_inst(z_rd_inst), .rd_dbg(z_rd_dbg),
    .rd_trig(z_rd_trig), .rd_last(z_rd_last)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dbg_of(input logic [31:0] inst);
    return 16'hA5A5 ^ inst[15:0] ^ {inst[7:0], 8'h3C};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst);
    cap_valid = v;
    cap_inst  = inst;
    cap_dbg   = dbg_of(inst);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic expect_sc(input string name, input logic [1:0] st, input logic [3:0] cnt);
    checks++;
    if (state_o !== st) begin
      errors++;
      $display("FAIL %s state: got %b expected %b", name, state_o, st);
    end
    checks++;
    if (count_o !== cnt) begin
      errors++;
      $display("FAIL %s count: got %0d expected %0d", name, count_o, cnt);
    end
  endtask

  // Holds rd_req for n cycles and checks each returned entry, then the drain.
  task automatic read_seq(input string name, input int n,
                          input logic [31:0] ei [8], input logic et [8]);
    rd_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_inst !== ei[k] || rd_dbg !== dbg_of(ei[k]) ||
          rd_trig !== et[k] || rd_last !== (k == n - 1)) begin
        errors++;
        $display("FAIL %s entry %0d: got v=%b inst=%0h dbg=%h trig=%b last=%b expected v=1 inst=%0h dbg=%h trig=%b last=%b",
                 name, k, rd_valid, rd_inst, rd_dbg, rd_trig, rd_last,
                 ei[k], dbg_of(ei[k]), et[k], k == n - 1);
      end
    end
    rd_req = 1'b0;
    expect_sc({name, "_drained"}, 2'b00, 4'd0);
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s rd_valid_after: got %b expected 0", name, rd_valid);
    end
  endtask

  task automatic test_reset();
    expect_sc("reset", 2'b00, 4'd0);
    checks++;
    if (done !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || z_state !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b rd_valid=%b rd_last=%b z_state=%b expected all 0",
               done, rd_valid, rd_last, z_state);
    end
  endtask

  task automatic test_reset_mid_post();
    trig_inst = 32'd10;
    trig_mask = 32'hFFFF_FFFF;
    do_arm();
    for (int i = 0; i <= 11; i++) begin
      drive(1'b1, i);
      step();
    end
    drive(1'b0, 0);
    expect_sc("mid_post", 2'b10, 4'd8);
    rst = 1'b0;
    step();
    expect_sc("reset_mid_post", 2'b00, 4'd0);
    checks++;
    if (rd_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_post_rd: got rd_valid=%b done=%b expected 0 0", rd_valid, done);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd10);
      step();
    end
    drive(1'b0, 0);
    expect_sc("idle_ignores_capture", 2'b00, 4'd0);
  endtask

  task automatic test_wrap_trigger();
    logic [31:0] ei [8];
    logic        et [8];
    trig_inst = 32'd10;
    trig_mask = 32'hFFFF_FFFF;
    do_arm();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, i);
      step();
      if (i == 12) expect_sc("wrap_i12", 2'b10, 4'd8);
      if (i == 13) expect_sc("wrap_i13", 2'b11, 4'd8);
    end
    drive(1'b0, 0);
    expect_sc("wrap_frozen", 2'b11, 4'd8);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_done: got %b expected 1", done);
    end
    for (int k = 0; k < 8; k++) begin
      ei[k] = 32'(k + 6);
      et[k] = (k + 6 == 10);
    end
    read_seq("wrap_read", 8, ei, et);
  endtask

  task automatic test_early_trigger();
    logic [31:0] ei [8];
    logic        et [8];
    trig_inst = 32'd1;
    trig_mask = 32'hFFFF_FFFF;
    do_arm();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i);
      step();
    end
    drive(1'b0, 0);
    expect_sc("early", 2'b11, 4'd5);
    for (int k = 0; k < 8; k++) begin
      ei[k] = 32'(k);
      et[k] = (k == 1);
    end
    read_seq("early_read", 5, ei, et);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_sixth_read: got rd_valid=%b expected 0", rd_valid);
    end
  endtask

  task automatic test_post_zero();
    trig_mask = 32'h0;
    trig_inst = 32'hDEAD_BEEF;
    do_arm();
    drive(1'b1, 32'h55);
    step();
    drive(1'b0, 0);
    checks++;
    if (z_state !== 2'b11 || z_done !== 1'b1 || z_count !== 4'd1) begin
      errors++;
      $display("FAIL post0_done: got state=%b done=%b count=%0d expected 11 1 1",
               z_state, z_done, z_count);
    end
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    checks++;
    if (z_rd_valid !== 1'b1 || z_rd_inst !== 32'h55 || z_rd_dbg !== dbg_of(32'h55) ||
        z_rd_trig !== 1'b1 || z_rd_last !== 1'b1) begin
      errors++;
      $display("FAIL post0_read: got v=%b inst=%0h dbg=%h trig=%b last=%b expected 1 55 %h 1 1",
               z_rd_valid, z_rd_inst, z_rd_dbg, z_rd_trig, z_rd_last, dbg_of(32'h55));
    end
    checks++;
    if (z_state !== 2'b00 || z_count !== 4'd0) begin
      errors++;
      $display("FAIL post0_idle: got state=%b count=%0d expected 00 0", z_state, z_count);
    end
    step();
    checks++;
    if (z_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL post0_rd_valid_after: got %b expected 0", z_rd_valid);
    end
  endtask

  task automatic test_arm_priority();
    trig_inst = 32'd7;
    trig_mask = 32'hFFFF_FFFF;
    do_arm();
    drive(1'b0, 32'd7);
    step();
    expect_sc("invalid_match", 2'b01, 4'd0);
    arm = 1'b1;
    drive(1'b1, 32'd7);
    step();
    arm = 1'b0;
    drive(1'b0, 0);
    expect_sc("arm_wins", 2'b01, 4'd0);
    drive(1'b1, 32'd8);
    step();
    drive(1'b0, 0);
    expect_sc("armed_write", 2'b01, 4'd1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ei [8];
    logic        et [8];
    logic        pv [6];
    logic [31:0] pi [6];
    ei = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd100, 32'd4, 32'd102};
    et = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    pv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    pi = '{32'd4, 32'd100, 32'd4, 32'd4, 32'd4, 32'd102};
    trig_inst = 32'd4;
    trig_mask = 32'hFFFF_FFFF;
    do_arm();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i);
      step();
    end
    expect_sc("toggle_trig", 2'b10, 4'd5);
    for (int j = 0; j < 6; j++) begin
      drive(pv[j], pi[j]);
      step();
      if (j == 4) expect_sc("toggle_post", 2'b10, 4'd7);
    end
    drive(1'b0, 0);
    expect_sc("toggle_done", 2'b11, 4'd8);
    read_seq("b2b_read", 8, ei, et);
  endtask

  initial begin
    #2;
    test_reset();
    rst = 1'b1;
    step();
    test_reset_mid_post();
    test_wrap_trigger();
    test_early_trigger();
    test_post_zero();
    test_arm_priority();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
